// File: rtl/fft_bitrev_buffer.sv
// Ping-pong frame buffer that replays each captured frame in natural or
// bit-reversed order, with the mode latched on the frame's first sample.
module fft_bitrev_buffer #(
  parameter int FLOAT_PRECISION = 64,
  parameter int logn            = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic                       bitrev_en,
  input  logic [FLOAT_PRECISION-1:0] fi_re,
  input  logic [FLOAT_PRECISION-1:0] fi_im,
  output logic                       out_valid,
  output logic                       out_last,
  output logic [FLOAT_PRECISION-1:0] fo_re,
  output logic [FLOAT_PRECISION-1:0] fo_im
);

  localparam int N = 1 << logn;
  localparam int W = 2 * FLOAT_PRECISION;

  typedef logic [logn-1:0] idx_t;
  typedef enum logic {IDLE, READ} state_e;

  localparam idx_t LAST = '1;

  function automatic idx_t bitrev(input idx_t a);
    idx_t r;
    for (int i = 0; i < logn; i++) r[i] = a[logn-1-i];
    return r;
  endfunction

  logic [W-1:0] mem_q [2][N];

  idx_t       wptr_q, wptr_d;
  logic       wbank_q, wbank_d;
  logic [1:0] full_q, full_d;
  logic [1:0] mode_q, mode_d;

  state_e     state_q, state_d;
  idx_t       rptr_q, rptr_d;
  logic       rbank_q, rbank_d;

  logic       rd_en, rel;
  idx_t       rd_idx, rd_addr;
  logic [W-1:0] rd_data;

  logic                       ov_q, ol_q;
  logic [FLOAT_PRECISION-1:0] re_q, im_q;

  assign rd_idx  = (state_q == IDLE) ? '0 : rptr_q;
  assign rd_addr = mode_q[rbank_q] ? bitrev(rd_idx) : rd_idx;
  assign rd_data = mem_q[rbank_q][rd_addr];

  always_comb begin
    state_d = state_q;
    rptr_d  = rptr_q;
    rbank_d = rbank_q;
    rd_en   = 1'b0;
    rel     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (full_q[rbank_q]) begin
          rd_en   = 1'b1;
          rptr_d  = idx_t'(1);
          state_d = READ;
        end
      end
      READ: begin
        rd_en  = 1'b1;
        rptr_d = rptr_q + idx_t'(1);
        if (rptr_q == LAST) begin
          rel     = 1'b1;
          rbank_d = ~rbank_q;
          // Chain straight into the other bank when it is already waiting
          state_d = full_q[~rbank_q] ? READ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wptr_d  = wptr_q;
    wbank_d = wbank_q;
    mode_d  = mode_q;
    full_d  = full_q;
    if (rel) full_d[rbank_q] = 1'b0;
    if (in_valid) begin
      if (wptr_q == '0) mode_d[wbank_q] = bitrev_en;
      wptr_d = wptr_q + idx_t'(1);
      if (wptr_q == LAST) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) mem_q[wbank_q][wptr_q] <= {fi_re, fi_im};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      wbank_q <= 1'b0;
      full_q  <= '0;
      mode_q  <= '0;
      state_q <= IDLE;
      rptr_q  <= '0;
      rbank_q <= 1'b0;
      ov_q    <= 1'b0;
      ol_q    <= 1'b0;
      re_q    <= '0;
      im_q    <= '0;
    end else begin
      wptr_q  <= wptr_d;
      wbank_q <= wbank_d;
      full_q  <= full_d;
      mode_q  <= mode_d;
      state_q <= state_d;
      rptr_q  <= rptr_d;
      rbank_q <= rbank_d;
      ov_q    <= rd_en;
      ol_q    <= rd_en && (rd_idx == LAST);
      re_q    <= rd_en ? rd_data[W-1:FLOAT_PRECISION] : '0;
      im_q    <= rd_en ? rd_data[FLOAT_PRECISION-1:0] : '0;
    end
  end

  assign out_valid = ov_q;
  assign out_last  = ol_q;
  assign fo_re     = re_q;
  assign fo_im     = im_q;

endmodule

// File: tb/tb_fft_bitrev_buffer.sv
// Randomised and directed bench for fft_bitrev_buffer (N=8, 64-bit parts)
// against a frame-level reference model.
module tb_fft_bitrev_buffer;

  localparam int FP = 64;
  localparam int LN = 3;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          bitrev_en;
  logic [FP-1:0] fi_re;
  logic [FP-1:0] fi_im;
  logic          out_valid;
  logic          out_last;
  logic [FP-1:0] fo_re;
  logic [FP-1:0] fo_im;

  fft_bitrev_buffer #(.FLOAT_PRECISION(FP), .logn(LN)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .bitrev_en(bitrev_en),
    .fi_re(fi_re),
    .fi_im(fi_im),
    .out_valid(out_valid),
    .out_last(out_last),
    .fo_re(fo_re),
    .fo_im(fo_im)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint      cyc;
    logic [63:0] re;
    logic [63:0] im;
    bit          last;
  } exp_t;

  exp_t        q[$];
  logic [63:0] fr_re[N];
  logic [63:0] fr_im[N];
  int          wcnt = 0;
  bit          fmode;
  longint      cyc = 0;
  longint      next_free = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  bit          run = 0;

  function automatic int rev3(input int x);
    int r = 0;
    int v = x;
    for (int i = 0; i < LN; i++) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  // Frame-level model: a full frame schedules N outputs starting the
  // cycle after its last capture (or after the previous frame drains).
  always @(posedge clk) begin
    cyc++;
    if (rst_n && in_valid) begin
      fr_re[wcnt] = fi_re;
      fr_im[wcnt] = fi_im;
      if (wcnt == 0) fmode = bitrev_en;
      wcnt++;
      if (wcnt == N) begin
        longint st;
        st = (cyc + 1 > next_free) ? cyc + 1 : next_free;
        for (int r = 0; r < N; r++) begin
          exp_t e;
          int   s;
          s      = fmode ? rev3(r) : r;
          e.cyc  = st + r;
          e.re   = fr_re[s];
          e.im   = fr_im[s];
          e.last = (r == N - 1);
          q.push_back(e);
        end
        next_free = st + N;
        wcnt      = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      bit ev;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        chk("missed_output", 64'd1, 64'd0);
        void'(q.pop_front());
      end
      ev = rst_n && q.size() > 0 && q[0].cyc == cyc;
      chk("out_valid", 64'(out_valid), 64'(ev));
      if (ev) begin
        chk("fo_re", fo_re, q[0].re);
        chk("fo_im", fo_im, q[0].im);
        chk("out_last", 64'(out_last), 64'(q[0].last));
        void'(q.pop_front());
      end else begin
        chk("idle_zero", {fo_re | fo_im}, 64'd0);
        chk("idle_last", 64'(out_last), 64'd0);
      end
    end
  end

  task automatic drv(input bit v, input bit be,
                     input logic [63:0] re, input logic [63:0] im);
    in_valid  = v;
    bitrev_en = be;
    fi_re     = v ? re : 64'd0;
    fi_im     = v ? im : 64'd0;
    @(negedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1'b0, 1'b0, 64'd0, 64'd0);
  endtask

  task automatic frame(input bit mode, input bit gaps);
    for (int k = 0; k < N; k++) begin
      bit be;
      be = (k == 0) ? mode : bit'(k % 2);
      drv(1'b1, be, 64'(k), 64'(100 + k));
      if (gaps && k != N - 1) begin
        drv(1'b0, bit'(k % 2 == 0), 64'd0, 64'd0);
        drv(1'b0, bit'(k % 2), 64'd0, 64'd0);
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_re", fo_re, 64'd0);
    chk("rst_im", fo_im, 64'd0);
    q.delete();
    wcnt      = 0;
    next_free = 0;
  endtask

  initial begin
    int lit_re[N];
    lit_re = '{0, 4, 2, 6, 1, 5, 3, 7};
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    bitrev_en = 1'b0;
    fi_re     = '0;
    fi_im     = '0;
    repeat (3) @(negedge clk);
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_data", {fo_re | fo_im}, 64'd0);
    #2;
    rst_n = 1'b1;
    run   = 1'b1;

    frame(1'b1, 1'b0);
    chk("model_frames", 64'(q.size()), 64'(N));
    if (q.size() == N) begin
      for (int i = 0; i < N; i++) begin
        chk("model_re", q[i].re, 64'(lit_re[i]));
        chk("model_im", q[i].im, 64'(100 + lit_re[i]));
        chk("model_last", 64'(q[i].last), 64'(i == N - 1));
      end
    end
    idle(12);

    frame(1'b0, 1'b0);
    idle(12);

    frame(1'b1, 1'b0);
    frame(1'b0, 1'b0);
    frame(1'b1, 1'b0);
    idle(12);

    frame(1'b1, 1'b1);
    idle(12);

    frame(1'b1, 1'b0);
    idle(4);
    do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    frame(1'b1, 1'b0);
    idle(12);

    drv(1'b1, 1'b0, 64'd55, 64'd66);
    drv(1'b1, 1'b0, 64'd56, 64'd67);
    do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    frame(1'b0, 1'b0);
    idle(12);

    for (int i = 0; i < 600; i++) begin
      bit v;
      v = (i < 200) ? 1'b1 : ($urandom_range(0, 3) != 0);
      drv(v, 1'($urandom_range(0, 1)),
          {$urandom, $urandom}, {$urandom, $urandom});
    end
    idle(24);
    chk("drained", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
